// File: rtl/vscale_dmem_rr_arbiter.sv
// Shares one HASTI data-memory master port among NUM_CORES core-side ports.
// The arbiter grants in round-robin order or to an externally selected core, and buffers responses that a stalled core cannot take yet.
`ifndef NUM_CORES
`define NUM_CORES 2
`endif
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 1
`endif

module vscale_dmem_rr_arbiter #(
  parameter int NUM_CORES      = `NUM_CORES,
  parameter int CORE_IDX_WIDTH = `CORE_IDX_WIDTH,
  parameter int SCHED_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES*32-1:0]   core_haddr,
  input  logic [NUM_CORES-1:0]      core_hwrite,
  input  logic [NUM_CORES*3-1:0]    core_hsize,
  input  logic [NUM_CORES*3-1:0]    core_hburst,
  input  logic [NUM_CORES-1:0]      core_hmastlock,
  input  logic [NUM_CORES*4-1:0]    core_hprot,
  input  logic [NUM_CORES*2-1:0]    core_htrans,
  input  logic [NUM_CORES*32-1:0]   core_hwdata,
  output logic [NUM_CORES*32-1:0]   core_hrdata,
  output logic [NUM_CORES-1:0]      core_hready,
  output logic [NUM_CORES-1:0]      core_hresp,
  output logic [31:0]               dmem_haddr,
  output logic                      dmem_hwrite,
  output logic [2:0]                dmem_hsize,
  output logic [2:0]                dmem_hburst,
  output logic                      dmem_hmastlock,
  output logic [3:0]                dmem_hprot,
  output logic [1:0]                dmem_htrans,
  output logic [31:0]               dmem_hwdata,
  input  logic [31:0]               dmem_hrdata,
  input  logic                      dmem_hready,
  input  logic                      dmem_hresp,
  input  logic [CORE_IDX_WIDTH-1:0] next_core
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [CORE_IDX_WIDTH-1:0] rr_ptr;
  logic [CORE_IDX_WIDTH-1:0] dp_owner;
  logic                      dp_valid;
  logic [CORE_IDX_WIDTH-1:0] winner;
  logic                      found;
  logic                      grant;
  logic [NUM_CORES-1:0]      req;
  logic [NUM_CORES-1:0]      addr_ok;
  logic [NUM_CORES-1:0]      data_ok;
  logic [NUM_CORES-1:0]      held;
  logic [NUM_CORES-1:0]      hold_resp;
  logic [31:0]               hold_rdata [NUM_CORES];

  // NONSEQ (2'b10) and SEQ (2'b11) both have the upper htrans bit set.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) req[i] = core_htrans[2*i+1];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    if (SCHED_MODE == 1) begin
      if (int'(next_core) < NUM_CORES && req[next_core]) begin
        winner = next_core;
        found  = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!found && req[(int'(rr_ptr) + k) % NUM_CORES]) begin
          winner = CORE_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_CORES);
          found  = 1'b1;
        end
      end
    end
    grant = found && dmem_hready && !reset;
  end

  always_comb begin
    dmem_haddr     = '0;
    dmem_hwrite    = 1'b0;
    dmem_hsize     = '0;
    dmem_hburst    = '0;
    dmem_hmastlock = 1'b0;
    dmem_hprot     = '0;
    dmem_htrans    = HTRANS_IDLE;
    if (grant) begin
      dmem_haddr     = core_haddr[int'(winner)*32 +: 32];
      dmem_hwrite    = core_hwrite[winner];
      dmem_hsize     = core_hsize[int'(winner)*3 +: 3];
      dmem_hburst    = core_hburst[int'(winner)*3 +: 3];
      dmem_hmastlock = core_hmastlock[winner];
      dmem_hprot     = core_hprot[int'(winner)*4 +: 4];
      dmem_htrans    = core_htrans[int'(winner)*2 +: 2];
    end
    dmem_hwdata = (dp_valid && !reset) ? core_hwdata[int'(dp_owner)*32 +: 32] : '0;
  end

  // A core stalls if its own data phase is waiting on memory or its address phase lost arbitration.
  always_comb begin
    core_hready = '0;
    core_hresp  = '0;
    core_hrdata = '0;
    addr_ok     = '0;
    data_ok     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      data_ok[i] = held[i] || !(dp_valid && int'(dp_owner) == i) || dmem_hready;
      addr_ok[i] = !req[i] || (grant && int'(winner) == i);
      core_hready[i] = reset || (data_ok[i] && addr_ok[i]);
      core_hresp[i]  = !reset && (held[i] ? hold_resp[i] : dmem_hresp);
      core_hrdata[32*i +: 32] = held[i] ? hold_rdata[i] : dmem_hrdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      dp_owner <= '0;
      dp_valid <= 1'b0;
      held     <= '0;
      hold_resp <= '0;
      // NOTE: the hold buffers are few and small, so they are cleared on reset like ordinary registers.
      for (int i = 0; i < NUM_CORES; i++) hold_rdata[i] <= '0;
    end else begin
      if (grant) begin
        rr_ptr   <= CORE_IDX_WIDTH'((int'(winner) + 1) % NUM_CORES);
        dp_owner <= winner;
        dp_valid <= 1'b1;
      end else if (dmem_hready) begin
        dp_valid <= 1'b0;
      end
      // Response arrives while the owner is stalled on its next address phase: park it.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (dp_valid && int'(dp_owner) == i && dmem_hready && !addr_ok[i]) begin
          hold_rdata[i] <= dmem_hrdata;
          hold_resp[i]  <= dmem_hresp;
          held[i]       <= 1'b1;
        end else if (core_hready[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/vscale_dmem_rr_arbiter.md
VSCALE_DMEM_RR_ARBITER -- requirements
Module: vscale_dmem_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default `NUM_CORES, number of core-side HASTI data ports.
REQ-002 SHALL have parameter CORE_IDX_WIDTH, default `CORE_IDX_WIDTH, width of the core index.
REQ-003 SHALL have parameter SCHED_MODE, default 0; 0 = round-robin, 1 = externally directed via next_core.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have core_haddr/core_hwrite/core_hsize/core_hburst/core_hmastlock/core_hprot/core_htrans/core_hwdata, inputs, NUM_CORES x (32/1/3/3/1/4/2/32); core i occupies bits [W*i+W-1:W*i].
REQ-007 SHALL have core_hrdata/core_hready/core_hresp, outputs, NUM_CORES x (32/1/1), per-core responses, same packing.
REQ-008 SHALL have dmem_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans/hwdata, outputs, 32/1/3/3/1/4/2/32, single master port to shared data memory.
REQ-009 SHALL have dmem_hrdata/dmem_hready/dmem_hresp, inputs, 32/1/1, shared memory response.
REQ-010 SHALL have next_core, input, CORE_IDX_WIDTH, only core eligible for grant when SCHED_MODE=1.

Function
REQ-011 Core i requests when core_htrans[i] is NONSEQ or SEQ.
REQ-012 Grant SHALL be evaluated combinationally each cycle; no core is granted while dmem_hready=0 or reset=1.
REQ-013 SCHED_MODE=0: winner = first requesting core scanning from rr_ptr upward, modulo NUM_CORES.
REQ-014 SCHED_MODE=1: winner = next_core iff it requests; otherwise no grant; next_core >= NUM_CORES means no grant.
REQ-015 dmem address-phase outputs SHALL mux from the winner; with no winner, dmem_htrans = IDLE (2'b00) and other address-phase outputs = 0.
REQ-016 On a grant: rr_ptr <= (winner+1) mod NUM_CORES, dp_owner <= winner, dp_valid <= 1; on a dmem_hready=1 cycle with no grant, dp_valid <= 0; on dmem_hready=0, rr_ptr/dp_owner/dp_valid hold.
REQ-017 dmem_hwdata SHALL mux core_hwdata of dp_owner; 0 when dp_valid=0.
REQ-018 data_ok[i] = 1 if held[i], or if not (dp_valid and dp_owner==i); else dmem_hready.
REQ-019 addr_ok[i] = 1 if core i is not requesting or is the winner; else 0.
REQ-020 core_hready[i] SHALL equal data_ok[i] AND addr_ok[i].
REQ-021 If dp_valid, dp_owner==i, dmem_hready=1 and addr_ok[i]=0: hold_rdata[i] <= dmem_hrdata, hold_resp[i] <= dmem_hresp, held[i] <= 1.
REQ-022 held[i] SHALL clear on any cycle with core_hready[i]=1.
REQ-023 core_hrdata[i]/core_hresp[i] = hold registers when held[i]=1, else dmem_hrdata/dmem_hresp.
REQ-024 A core never has more than one outstanding data phase; held[i] and dp_owner==i with dp_valid are mutually exclusive.
REQ-025 Back-to-back grant to the same core is allowed when it is the sole requester; latency from request to dmem address phase is 0 cycles when granted.

Reset
REQ-026 While reset=1: rr_ptr=0, dp_owner=0, dp_valid=0, held=0, hold registers=0 at the next edge.
REQ-027 While reset=1: dmem_htrans=IDLE, dmem_hwdata=0, all core_hready=1, core_hresp=0; an in-flight data phase is abandoned, not replayed.

Verification
REQ-028 NUM_CORES=2, core0 NONSEQ read 0x100, dmem_hready=1 -> same cycle dmem_haddr=0x100, core_hready[0]=1; next cycle dmem_hrdata=0xDEADBEEF reaches core_hrdata[0] with core_hready[0]=1.
REQ-029 After reset, both cores request continuously, dmem_hready=1 -> grants alternate 0,1,0,1; loser core_hready=0 each cycle.
REQ-030 Core0 read completes (dmem_hrdata=0x1234) while core1 wins and core0 requests again -> core_hready[0]=0, held[0]=1; next cycle core0 wins, core_hready[0]=1, core_hrdata[0]=0x1234.
REQ-031 Core1 write 0xCAFE in data phase, dmem_hready=0 for 2 cycles -> no grant, dmem_hwdata=0xCAFE stable, rr_ptr unchanged, all requesting cores hready=0.
REQ-032 SCHED_MODE=1, next_core=1, only core0 requests -> dmem_htrans=IDLE, core_hready[0]=0; next_core=0 -> core0 granted.
REQ-033 reset asserted mid data phase -> following cycle dp_valid=0, held=0, dmem_htrans=IDLE, all core_hready=1.
